// File: rtl/fft_pkg.sv
// Shared state type and index-shift helpers for the radix-2 FFT stage sequencer
// and its butterfly address generator.
package fft_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } fft_seq_state_t;

   // Distance between the two operands of a butterfly in stage stg.
   function automatic int unsigned fft_span(input int unsigned stg);
      return 32'd1 << stg;
   endfunction

   // Left shift that turns the in-group offset j into the twiddle exponent.
   function automatic int unsigned fft_tw_shift(input int unsigned log2n,
                                                input int unsigned stg);
      return log2n - 32'd1 - stg;
   endfunction

endpackage

// File: rtl/fft_bf_addr_gen.sv
// Combinational butterfly address generator: maps (stage, butterfly count) to the
// operand pair, twiddle exponent and end-of-stage flag.
module fft_bf_addr_gen
   import fft_pkg::*;
#(
   parameter  int SAMPLES = 8,
   localparam int LOG2N   = $clog2(SAMPLES),
   localparam int IDX_W   = LOG2N,
   localparam int STG_W   = $clog2(LOG2N),
   localparam int TW_W    = LOG2N - 1,
   localparam int CNT_W   = LOG2N - 1
) (
   input  logic [STG_W-1:0] stg,
   input  logic [CNT_W-1:0] cnt,
   output logic [IDX_W-1:0] a,
   output logic [IDX_W-1:0] b,
   output logic [TW_W-1:0]  tw,
   output logic             last
);

   logic [IDX_W-1:0] w_span;
   logic [IDX_W-1:0] w_cnt;
   logic [IDX_W-1:0] w_j;
   logic [IDX_W-1:0] w_grp;
   logic [IDX_W-1:0] w_a;

   // Group index is the outer loop and j the inner loop within each stage.
   always_comb begin
      w_span = IDX_W'(fft_span(32'(stg)));
      w_cnt  = IDX_W'(cnt);
      w_j    = w_cnt & (w_span - IDX_W'(1));
      w_grp  = w_cnt >> stg;
      w_a    = ((w_grp << stg) << 1) | w_j;
   end

   assign a    = w_a;
   assign b    = w_a + w_span;
   assign tw   = TW_W'(w_j << fft_tw_shift(LOG2N, 32'(stg)));
   assign last = (cnt == CNT_W'(SAMPLES / 2 - 1));

endmodule

// File: rtl/fft_stage_sequencer.sv
// Control sequencer for an in-place radix-2 FFT: issues one butterfly descriptor per
// handshake, stage by stage, and waits for the datapath to drain between stages.
module fft_stage_sequencer
   import fft_pkg::*;
#(
   parameter  int SAMPLES = 8,
   localparam int LOG2N   = $clog2(SAMPLES),
   localparam int IDX_W   = LOG2N,
   localparam int STG_W   = $clog2(LOG2N),
   localparam int TW_W    = LOG2N - 1,
   localparam int CNT_W   = LOG2N - 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic             pipe_idle,
   output logic             bf_valid,
   input  logic             bf_ready,
   output logic [STG_W-1:0] bf_stage,
   output logic [IDX_W-1:0] bf_idx_a,
   output logic [IDX_W-1:0] bf_idx_b,
   output logic [TW_W-1:0]  bf_tw,
   output logic             bf_last,
   output logic             busy,
   output logic             done
);

   fft_seq_state_t   r_state;
   fft_seq_state_t   w_state_next;
   logic [STG_W-1:0] r_stg;
   logic [STG_W-1:0] w_stg_next;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_next;
   logic             r_done;
   logic             w_done_next;

   logic             w_last;
   logic             w_xfer;
   logic             w_final_stage;

   fft_bf_addr_gen #(
      .SAMPLES (SAMPLES)
   ) u_addr_gen (
      .stg  (r_stg),
      .cnt  (r_cnt),
      .a    (bf_idx_a),
      .b    (bf_idx_b),
      .tw   (bf_tw),
      .last (w_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_stg   <= '0;
         r_cnt   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_stg   <= w_stg_next;
         r_cnt   <= w_cnt_next;
         r_done  <= w_done_next;
      end
   end

   assign w_xfer        = (r_state == ISSUE) && bf_ready;
   assign w_final_stage = (r_stg == STG_W'(LOG2N - 1));

   // Abort overrides every transition, including a start seen in the same cycle.
   always_comb begin
      w_state_next = r_state;
      w_stg_next   = r_stg;
      w_cnt_next   = r_cnt;
      w_done_next  = 1'b0;
      if (abort) begin
         w_state_next = IDLE;
         w_stg_next   = '0;
         w_cnt_next   = '0;
      end else begin
         case (r_state)
            IDLE: begin
               w_stg_next = '0;
               w_cnt_next = '0;
               if (start) begin
                  w_state_next = ISSUE;
               end
            end
            ISSUE: begin
               if (w_xfer) begin
                  if (w_last) begin
                     w_state_next = DRAIN;
                     w_cnt_next   = '0;
                  end else begin
                     w_cnt_next = r_cnt + CNT_W'(1);
                  end
               end
            end
            DRAIN: begin
               if (pipe_idle) begin
                  if (w_final_stage) begin
                     w_state_next = IDLE;
                     w_stg_next   = '0;
                     w_done_next  = 1'b1;
                  end else begin
                     w_stg_next   = r_stg + STG_W'(1);
                     w_state_next = ISSUE;
                  end
               end
            end
            default: begin
               w_state_next = IDLE;
               w_stg_next   = '0;
               w_cnt_next   = '0;
            end
         endcase
      end
   end

   assign bf_valid = (r_state == ISSUE);
   assign busy     = (r_state != IDLE);
   assign done     = r_done;
   assign bf_stage = r_stg;
   assign bf_last  = w_last;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Self-checking bench for fft_stage_sequencer at SAMPLES = 4, 8 and 16, checked
// against a loop-nest reference of the butterfly ordering and the stage protocol.
module tb_fft_stage_sequencer;

   logic clk = 1'b0;
   logic rst_n;
   logic start;
   logic abort;
   logic pipe_idle;
   logic bf_ready;

   always #5 clk = ~clk;

   logic       v8, l8, y8, d8;
   logic [1:0] s8;
   logic [2:0] a8, b8;
   logic [1:0] t8;

   logic       v4, l4, y4, d4;
   logic [0:0] s4;
   logic [1:0] a4, b4;
   logic [0:0] t4;

   logic       v16, l16, y16, d16;
   logic [1:0] s16;
   logic [3:0] a16, b16;
   logic [2:0] t16;

   fft_stage_sequencer #(.SAMPLES(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .pipe_idle(pipe_idle),
      .bf_valid(v8), .bf_ready(bf_ready), .bf_stage(s8), .bf_idx_a(a8), .bf_idx_b(b8),
      .bf_tw(t8), .bf_last(l8), .busy(y8), .done(d8));

   fft_stage_sequencer #(.SAMPLES(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .pipe_idle(pipe_idle),
      .bf_valid(v4), .bf_ready(bf_ready), .bf_stage(s4), .bf_idx_a(a4), .bf_idx_b(b4),
      .bf_tw(t4), .bf_last(l4), .busy(y4), .done(d4));

   fft_stage_sequencer #(.SAMPLES(16)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .pipe_idle(pipe_idle),
      .bf_valid(v16), .bf_ready(bf_ready), .bf_stage(s16), .bf_idx_a(a16), .bf_idx_b(b16),
      .bf_tw(t16), .bf_last(l16), .busy(y16), .done(d16));

   int          sel = 8;
   logic [31:0] o_stage, o_a, o_b, o_tw;
   logic        o_valid, o_last, o_busy, o_done;

   always_comb begin
      o_stage = 32'(s8);
      o_a     = 32'(a8);
      o_b     = 32'(b8);
      o_tw    = 32'(t8);
      o_valid = v8;
      o_last  = l8;
      o_busy  = y8;
      o_done  = d8;
      if (sel == 4) begin
         o_stage = 32'(s4);
         o_a     = 32'(a4);
         o_b     = 32'(b4);
         o_tw    = 32'(t4);
         o_valid = v4;
         o_last  = l4;
         o_busy  = y4;
         o_done  = d4;
      end else if (sel == 16) begin
         o_stage = 32'(s16);
         o_a     = 32'(a16);
         o_b     = 32'(b16);
         o_tw    = 32'(t16);
         o_valid = v16;
         o_last  = l16;
         o_busy  = y16;
         o_done  = d16;
      end
   end

   int total = 0;
   int bad   = 0;

   typedef struct {
      int stage;
      int a;
      int b;
      int tw;
      bit last;
   } desc_t;

   desc_t exp_q[$];

   localparam int P_IDLE  = 0;
   localparam int P_ISSUE = 1;
   localparam int P_DRAIN = 2;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string pfx);
      chk({pfx, "_valid"}, 32'(o_valid), 0);
      chk({pfx, "_busy"},  32'(o_busy), 0);
      chk({pfx, "_done"},  32'(o_done), 0);
      chk({pfx, "_stage"}, o_stage, 0);
      chk({pfx, "_a"},     o_a, 0);
      chk({pfx, "_b"},     o_b, 1);
      chk({pfx, "_tw"},    o_tw, 0);
      chk({pfx, "_last"},  32'(o_last), 0);
   endtask

   // Reference order: for each stage, groups outer, in-group offset inner.
   task automatic build_model(input int n);
      int    half;
      int    groups;
      int    k;
      desc_t d;
      exp_q.delete();
      for (int s = 0; (1 << s) < n; s++) begin
         half   = 1 << s;
         groups = n / (2 * half);
         k      = 0;
         for (int g = 0; g < groups; g++) begin
            for (int j = 0; j < half; j++) begin
               d.stage = s;
               d.a     = g * 2 * half + j;
               d.b     = d.a + half;
               d.tw    = j * groups;
               d.last  = (k == n / 2 - 1);
               k++;
               exp_q.push_back(d);
            end
         end
      end
   endtask

   task automatic run_xform(input int n, input int ready_pct, input int drain_hold,
                            input int abort_at, input int rst_stage, input bit start_noise,
                            output int done_cyc);
      int          phase, pos, stage_m, dcnt, cyc, stages, xfers;
      bit          exp_done, cur_done, done_next, stalled, finished, rdy;
      int          pv_a, pv_b, pv_tw, pv_stage, pv_last;
      logic [31:0] mask;
      sel = n;
      build_model(n);
      stages   = exp_q.size() / (n / 2);
      phase    = P_ISSUE;
      pos      = 0;
      stage_m  = 0;
      dcnt     = 0;
      exp_done = 0;
      stalled  = 0;
      finished = 0;
      xfers    = 0;
      mask     = '0;
      done_cyc = -1;
      pv_a = 0; pv_b = 0; pv_tw = 0; pv_stage = 0; pv_last = 0;

      @(negedge clk);
      abort = 1'b1; start = 1'b0; bf_ready = 1'b0; pipe_idle = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk_idle("pre_start");
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc   = 1;

      while (cyc < 400) begin
         cur_done = exp_done;
         chk("valid", 32'(o_valid), 32'(phase == P_ISSUE));
         chk("busy",  32'(o_busy),  32'(phase != P_IDLE));
         chk("done",  32'(o_done),  32'(cur_done));
         if (phase == P_ISSUE) begin
            chk("stage", o_stage, exp_q[pos].stage);
            chk("idx_a", o_a,     exp_q[pos].a);
            chk("idx_b", o_b,     exp_q[pos].b);
            chk("tw",    o_tw,    exp_q[pos].tw);
            chk("last",  32'(o_last), 32'(exp_q[pos].last));
            if (stalled) begin
               chk("hold_a",     o_a, pv_a);
               chk("hold_b",     o_b, pv_b);
               chk("hold_tw",    o_tw, pv_tw);
               chk("hold_stage", o_stage, pv_stage);
               chk("hold_last",  32'(o_last), pv_last);
            end
         end else if (phase == P_IDLE) begin
            chk("idle_stage", o_stage, 0);
            chk("idle_a", o_a, 0);
            chk("idle_b", o_b, 1);
            chk("idle_tw", o_tw, 0);
         end else begin
            chk("drain_stage", o_stage, stage_m);
         end
         if (cur_done) done_cyc = cyc;
         if (phase == P_IDLE && !cur_done) begin
            finished = 1;
            break;
         end

         done_next = 0;
         start     = (start_noise && phase != P_IDLE) ? 1'($urandom_range(0, 1)) : 1'b0;
         abort     = 1'b0;
         if (phase == P_ISSUE) begin
            if (pos == abort_at) begin
               abort    = 1'b1;
               bf_ready = 1'b1;
               phase    = P_IDLE;
               stalled  = 0;
            end else begin
               rdy       = ($urandom_range(0, 99) < 32'(ready_pct));
               bf_ready  = rdy;
               pipe_idle = 1'($urandom_range(0, 1));
               pv_a = int'(o_a); pv_b = int'(o_b); pv_tw = int'(o_tw);
               pv_stage = int'(o_stage); pv_last = int'(o_last);
               if (rdy) begin
                  chk("b_minus_a", o_b - o_a, 1 << stage_m);
                  mask = mask | (32'd1 << o_a) | (32'd1 << o_b);
                  xfers++;
                  if (exp_q[pos].last) begin
                     chk("stage_cover", mask, (1 << n) - 1);
                     mask  = '0;
                     phase = P_DRAIN;
                     dcnt  = 0;
                  end
                  pos++;
               end
               stalled = !rdy;
            end
         end else if (phase == P_DRAIN) begin
            bf_ready = 1'($urandom_range(0, 1));
            if (rst_stage == stage_m && dcnt == 2) begin
               pipe_idle = 1'b0;
               #2 rst_n = 1'b0;
               #1;
               chk_idle("async_rst");
               @(negedge clk);
               chk_idle("in_rst");
               start = 1'b0;
               rst_n = 1'b1;
               @(negedge clk);
               chk_idle("after_rst");
               finished = 1;
               break;
            end
            pipe_idle = (dcnt >= drain_hold);
            dcnt++;
            if (pipe_idle) begin
               if (stage_m == stages - 1) begin
                  phase     = P_IDLE;
                  done_next = 1;
               end else begin
                  stage_m++;
                  phase = P_ISSUE;
               end
            end
         end
         exp_done = done_next;
         @(negedge clk);
         cyc++;
      end
      chk("finished_in_budget", 32'(finished), 1);
      start = 1'b0;
      abort = 1'b0;
      if (abort_at < 0 && rst_stage < 0) chk("xfer_count", xfers, (n / 2) * stages);
   endtask

   int dc;

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; pipe_idle = 1'b1; bf_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk_idle("reset");
      rst_n = 1'b1;
      @(negedge clk);
      chk_idle("post_reset");

      run_xform(8, 100, 0, -1, -1, 0, dc);
      chk("t1_done_cycle", dc, 16);

      run_xform(8, 50, 0, -1, -1, 0, dc);

      run_xform(8, 100, 5, -1, -1, 0, dc);
      chk("t3_done_cycle", dc, 31);

      run_xform(8, 70, 1, 6, -1, 0, dc);
      chk("t4_abort_no_done", dc, -1);
      run_xform(8, 100, 0, -1, -1, 0, dc);
      chk("t4_restart_done_cycle", dc, 16);

      @(negedge clk);
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      chk("start_abort_busy", 32'(o_busy), 0);
      chk("start_abort_valid", 32'(o_valid), 0);
      @(negedge clk);
      chk("start_abort_busy2", 32'(o_busy), 0);

      run_xform(8, 60, 1, -1, -1, 1, dc);
      run_xform(8, 80, 4, -1, 1, 1, dc);
      chk("t5_reset_no_done", dc, -1);
      run_xform(8, 100, 0, -1, -1, 0, dc);
      chk("t5_after_reset_done_cycle", dc, 16);

      run_xform(4, 50, 2, -1, -1, 0, dc);
      run_xform(4, 100, 0, -1, -1, 0, dc);
      chk("n4_done_cycle", dc, 7);
      run_xform(16, 50, 1, -1, -1, 0, dc);
      run_xform(16, 100, 0, -1, -1, 0, dc);
      chk("n16_done_cycle", dc, 37);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
